// File: rtl/ptc_axi2mfb.sv
// ptc_axi2mfb: receive-side converter from the PCIe hard-IP AXI4-Stream
// completion (RC) interface to the PTC MFB bus. Each AXI word carries at most
// one frame (no straddling); SOF comes from frame tracking, EOF and its item
// position from TLAST and the highest set TKEEP bit.
// A 2-entry output buffer gives one cycle of latency and a registered RC_READY.
// Optional build macro PTC_AXI2MFB_KEEP_CHECK_EN adds a sticky TKEEP error flag;
// without it KEEP_ERR is tied low.
module ptc_axi2mfb #(
  parameter int MFB_REGIONS      = 2,
  parameter int MFB_REGION_SIZE  = 1,
  parameter int MFB_BLOCK_SIZE   = 8,
  parameter int MFB_ITEM_WIDTH   = 32,  // only 32 is meaningful: one item per TKEEP bit
  parameter int AXI_RCUSER_WIDTH = 161,
  localparam int ITEMS = MFB_REGION_SIZE * MFB_BLOCK_SIZE,
  localparam int DW    = MFB_REGIONS * ITEMS * MFB_ITEM_WIDTH,
  localparam int KW    = DW / 32,
  localparam int EPW   = (ITEMS > 1) ? $clog2(ITEMS) : 1,
  localparam int SPW   = (MFB_REGION_SIZE > 1) ? $clog2(MFB_REGION_SIZE) : 1
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [DW-1:0]                   RC_DATA,
  input  logic [AXI_RCUSER_WIDTH-1:0]     RC_USER,
  input  logic                            RC_LAST,
  input  logic [KW-1:0]                   RC_KEEP,
  input  logic                            RC_VALID,
  output logic                            RC_READY,
  output logic [DW-1:0]                   TX_MFB_DATA,
  output logic [AXI_RCUSER_WIDTH-1:0]     TX_MFB_META,
  output logic [MFB_REGIONS-1:0]          TX_MFB_SOF,
  output logic [MFB_REGIONS-1:0]          TX_MFB_EOF,
  output logic [MFB_REGIONS*SPW-1:0]      TX_MFB_SOF_POS,
  output logic [MFB_REGIONS*EPW-1:0]      TX_MFB_EOF_POS,
  output logic                            TX_MFB_SRC_RDY,
  input  logic                            TX_MFB_DST_RDY,
  output logic                            KEEP_ERR
);

  localparam int HW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic                          rc_ready_q, rc_ready_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic                          wr_ptr_q, rd_ptr_q;
  logic                          push, pop, src_rdy;

  logic [DW-1:0]                 data_q   [2];
  logic [AXI_RCUSER_WIDTH-1:0]   meta_q   [2];
  logic [MFB_REGIONS-1:0]        sof_q    [2];
  logic [MFB_REGIONS-1:0]        eof_q    [2];
  logic [MFB_REGIONS*EPW-1:0]    eofpos_q [2];

  logic [HW-1:0]                 hi;
  logic [MFB_REGIONS-1:0]        sof_in, eof_in;
  logic [MFB_REGIONS*EPW-1:0]    eofpos_in;

  assign src_rdy = (cnt_q != 2'd0);
  assign push    = RC_VALID & rc_ready_q;
  assign pop     = src_rdy & TX_MFB_DST_RDY;

  // Beat decode: SOF from frame state, EOF region/item from the last valid dword
  always_comb begin
    hi        = '0;
    sof_in    = '0;
    eof_in    = '0;
    eofpos_in = '0;
    // an empty TKEEP on a LAST beat falls through as dword 0
    for (int i = 0; i < KW; i++) begin
      if (RC_KEEP[i]) hi = HW'(i);
    end
    if (state_q == IDLE) sof_in[0] = 1'b1;
    if (RC_LAST) begin
      for (int r = 0; r < MFB_REGIONS; r++) begin
        if (int'(hi) / ITEMS == r) begin
          eof_in[r]               = 1'b1;
          eofpos_in[r*EPW +: EPW] = EPW'(int'(hi) % ITEMS);
        end
      end
    end
  end

  // Frame tracking next state: a non-LAST beat opens a frame, a LAST beat closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (push && !RC_LAST) state_d = IN_FRAME;
      IN_FRAME: if (push &&  RC_LAST) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Buffer occupancy; ready is registered, so it looks at the post-update fill level
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    rc_ready_d = (cnt_d <= 2'd1);
  end

  // Control registers: frame state, pointers, fill level, ready
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rc_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rc_ready_q <= rc_ready_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer storage; cleared on reset so the TX bus reads zero during reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int e = 0; e < 2; e++) begin
        data_q[e]   <= '0;
        meta_q[e]   <= '0;
        sof_q[e]    <= '0;
        eof_q[e]    <= '0;
        eofpos_q[e] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q]   <= RC_DATA;
      meta_q[wr_ptr_q]   <= RC_USER;
      sof_q[wr_ptr_q]    <= sof_in;
      eof_q[wr_ptr_q]    <= eof_in;
      eofpos_q[wr_ptr_q] <= eofpos_in;
    end
  end

  assign RC_READY       = rc_ready_q;
  assign TX_MFB_SRC_RDY = src_rdy;
  assign TX_MFB_DATA    = data_q[rd_ptr_q];
  assign TX_MFB_META    = meta_q[rd_ptr_q];
  assign TX_MFB_SOF     = sof_q[rd_ptr_q];
  assign TX_MFB_EOF     = eof_q[rd_ptr_q];
  assign TX_MFB_EOF_POS = eofpos_q[rd_ptr_q];
  assign TX_MFB_SOF_POS = '0;

`ifdef PTC_AXI2MFB_KEEP_CHECK_EN
  logic keep_bad;
  logic keep_err_q;

  // Illegal TKEEP: LAST beat empty or with a gap, or a non-LAST beat not full
  always_comb begin
    if (RC_LAST) keep_bad = (RC_KEEP == '0) || ((RC_KEEP & (RC_KEEP + KW'(1))) != '0);
    else         keep_bad = (RC_KEEP != '1);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) keep_err_q <= 1'b0;
    else if (push && keep_bad) keep_err_q <= 1'b1;
  end

  assign KEEP_ERR = keep_err_q;
`else
  assign KEEP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ptc_axi2mfb.sv
// Testbench for ptc_axi2mfb: driver pushes the expected MFB word for every
// accepted AXI beat into a queue; a negedge monitor pops and compares each
// transferred word and checks that stalled output stays stable.
module tb_ptc_axi2mfb;

  localparam int DW  = 512;
  localparam int UW  = 161;
  localparam int KW  = 16;
  localparam int ITEMS = 8;
  localparam int EPW = 3;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] m;
    logic [1:0]    sof;
    logic [1:0]    eof;
    logic [5:0]    pos;
  } exp_t;

  logic           clk = 1'b0;
  logic           RST_N;
  logic [DW-1:0]  RC_DATA;
  logic [UW-1:0]  RC_USER;
  logic           RC_LAST;
  logic [KW-1:0]  RC_KEEP;
  logic           RC_VALID;
  logic           RC_READY;
  logic [DW-1:0]  TX_MFB_DATA;
  logic [UW-1:0]  TX_MFB_META;
  logic [1:0]     TX_MFB_SOF;
  logic [1:0]     TX_MFB_EOF;
  logic [1:0]     TX_MFB_SOF_POS;
  logic [5:0]     TX_MFB_EOF_POS;
  logic           TX_MFB_SRC_RDY;
  logic           TX_MFB_DST_RDY;
  logic           KEEP_ERR;

  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  int   dst_mode = 1;  // 0 random, 1 always ready, 2 stalled
  exp_t q[$];

  ptc_axi2mfb dut (
    .CLK(clk), .RST_N(RST_N),
    .RC_DATA(RC_DATA), .RC_USER(RC_USER), .RC_LAST(RC_LAST), .RC_KEEP(RC_KEEP),
    .RC_VALID(RC_VALID), .RC_READY(RC_READY),
    .TX_MFB_DATA(TX_MFB_DATA), .TX_MFB_META(TX_MFB_META),
    .TX_MFB_SOF(TX_MFB_SOF), .TX_MFB_EOF(TX_MFB_EOF),
    .TX_MFB_SOF_POS(TX_MFB_SOF_POS), .TX_MFB_EOF_POS(TX_MFB_EOF_POS),
    .TX_MFB_SRC_RDY(TX_MFB_SRC_RDY), .TX_MFB_DST_RDY(TX_MFB_DST_RDY),
    .KEEP_ERR(KEEP_ERR)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // Reference: SOF on the first beat of a frame; on the LAST beat the highest
  // kept dword h gives region h/8 and item h%8.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [UW-1:0] m,
                                 input logic last, input logic [KW-1:0] keep, input logic first);
    exp_t e;
    int   h, k;
    e.d = d; e.m = m;
    e.sof = first ? 2'b01 : 2'b00;
    e.eof = 2'b00;
    e.pos = 6'd0;
    if (last) begin
      h = 0;
      for (int i = 0; i < KW; i++) if (keep[i]) h = i;
      k = h / ITEMS;
      e.eof[k] = 1'b1;
      e.pos = 6'(h % ITEMS) << (k * EPW);
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rnd_meta();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
    return t[UW-1:0];
  endfunction

  // MFB ready driver
  always @(posedge clk) begin
    #1;
    case (dst_mode)
      0:       TX_MFB_DST_RDY = 1'($urandom_range(0, 1));
      1:       TX_MFB_DST_RDY = 1'b1;
      default: TX_MFB_DST_RDY = 1'b0;
    endcase
  end

  // Monitor: compare transferred words, check stalled words stay put
  exp_t       mon_e;
  logic       have_prev = 1'b0;
  logic [DW-1:0] prev_d;
  logic [UW-1:0] prev_m;
  logic [1:0] prev_sof, prev_eof;
  logic [5:0] prev_pos;

  always @(negedge clk) begin
    if (!RST_N) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("hold_vld",  DW'(TX_MFB_SRC_RDY), DW'(1'b1));
        chk("hold_data", TX_MFB_DATA, prev_d);
        chk("hold_meta", DW'(TX_MFB_META), DW'(prev_m));
        chk("hold_flags", DW'({TX_MFB_SOF, TX_MFB_EOF, TX_MFB_EOF_POS}),
            DW'({prev_sof, prev_eof, prev_pos}));
      end
      have_prev = 1'b0;
      if (TX_MFB_SRC_RDY) begin
        if (TX_MFB_DST_RDY) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word act=word_out req=none sof=%b eof=%b", TX_MFB_SOF, TX_MFB_EOF);
          end else begin
            mon_e = q.pop_front();
            chk("data",    TX_MFB_DATA, mon_e.d);
            chk("meta",    DW'(TX_MFB_META), DW'(mon_e.m));
            chk("sof",     DW'(TX_MFB_SOF), DW'(mon_e.sof));
            chk("eof",     DW'(TX_MFB_EOF), DW'(mon_e.eof));
            chk("eof_pos", DW'(TX_MFB_EOF_POS), DW'(mon_e.pos));
            chk("sof_pos", DW'(TX_MFB_SOF_POS), DW'(2'b00));
          end
        end else begin
          have_prev = 1'b1;
          prev_d = TX_MFB_DATA; prev_m = TX_MFB_META;
          prev_sof = TX_MFB_SOF; prev_eof = TX_MFB_EOF; prev_pos = TX_MFB_EOF_POS;
        end
      end
    end
  end

  // Present one beat (optional idle gap first), hold until accepted
  task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] m, input logic last,
                           input logic [KW-1:0] keep, input logic first, input int gap_pct);
    exp_t e;
    int   n;
    e = model(d, m, last, keep, first);
    @(posedge clk); #2;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      RC_VALID = 1'b0;
      @(posedge clk); #2;
    end
    RC_DATA = d; RC_USER = m; RC_LAST = last; RC_KEEP = keep; RC_VALID = 1'b1;
    n = 0;
    while (!RC_READY) begin
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout act=not_accepted req=accepted");
        RC_VALID = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
    q.push_back(e);
    n_acc++;
  endtask

  task automatic idle();
    @(posedge clk); #2;
    RC_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || TX_MFB_SRC_RDY) && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL drain act=pending%0d req=0", q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rc_ready"}, DW'(RC_READY), DW'(1'b0));
    chk({tag, "_src_rdy"},  DW'(TX_MFB_SRC_RDY), DW'(1'b0));
    chk({tag, "_sof_eof"},  DW'({TX_MFB_SOF, TX_MFB_EOF}), DW'(4'b0));
    chk({tag, "_pos"},      DW'({TX_MFB_SOF_POS, TX_MFB_EOF_POS}), DW'(8'b0));
    chk({tag, "_data"},     TX_MFB_DATA, DW'(1'b0));
    chk({tag, "_meta"},     DW'(TX_MFB_META), DW'(1'b0));
    chk({tag, "_keep_err"}, DW'(KEEP_ERR), DW'(1'b0));
  endtask

  initial begin
    int acc0, nb, c;
    logic [KW-1:0] kk;
    logic exp_err;
    RST_N = 1'b0; RC_VALID = 1'b0; RC_LAST = 1'b0; RC_KEEP = '0;
    RC_DATA = '0; RC_USER = '0; TX_MFB_DST_RDY = 1'b0;

    // reset state and ready sequencing after release
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("rst");
    RST_N = 1'b1;
    #1;
    chk("ready_first_cycle", DW'(RC_READY), DW'(1'b0));
    @(posedge clk); #2;
    chk("ready_after", DW'(RC_READY), DW'(1'b1));

    // single-beat frame, KEEP=003F
    send_beat(rnd_data(), rnd_meta(), 1'b1, 16'h003F, 1'b1, 0);
    idle();
    chk("lat_src_rdy", DW'(TX_MFB_SRC_RDY), DW'(1'b1));
    chk("lat_sof", DW'(TX_MFB_SOF), DW'(2'b01));
    chk("lat_eof", DW'(TX_MFB_EOF), DW'(2'b01));
    chk("lat_pos", DW'(TX_MFB_EOF_POS[2:0]), DW'(3'd5));
    wait_drain();

    // three-beat frame ending with KEEP=0FFF
    send_beat(rnd_data(), rnd_meta(), 1'b0, 16'hFFFF, 1'b1, 0);
    send_beat(rnd_data(), rnd_meta(), 1'b0, 16'hFFFF, 1'b0, 0);
    send_beat(rnd_data(), rnd_meta(), 1'b1, 16'h0FFF, 1'b0, 0);
    idle();
    wait_drain();

    // backpressure: only two beats fit while the sink is stalled
    dst_mode = 2;
    @(posedge clk); #2;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send_beat(rnd_data(), rnd_meta(), 1'(i == 4), 16'hFFFF, 1'(i == 0), 0);
        idle();
      end
      begin
        repeat (10) @(posedge clk);
        #3;
        chk("stall_accepted", DW'(n_acc - acc0), DW'(2));
        chk("stall_ready", DW'(RC_READY), DW'(1'b0));
        dst_mode = 1;
      end
    join
    wait_drain();

    // reset in the middle of a frame, then a fresh single-beat frame
    send_beat(rnd_data(), rnd_meta(), 1'b0, 16'hFFFF, 1'b1, 0);
    send_beat(rnd_data(), rnd_meta(), 1'b0, 16'hFFFF, 1'b0, 0);
    @(posedge clk); #2;
    RC_VALID = 1'b0;
    RST_N = 1'b0;
    q.delete();
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #2;
    RST_N = 1'b1;
    send_beat(rnd_data(), rnd_meta(), 1'b1, 16'hFFFF, 1'b1, 0);
    idle();
    chk("post_rst_sof", DW'(TX_MFB_SOF), DW'(2'b01));
    wait_drain();

    // random traffic with random sink backpressure
    dst_mode = 0;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 20);
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1) begin
          c = $urandom_range(1, 16);
          kk = 16'((32'd1 << c) - 32'd1);
          send_beat(rnd_data(), rnd_meta(), 1'b1, kk, 1'(b == 0), 30);
        end else begin
          send_beat(rnd_data(), rnd_meta(), 1'b0, 16'hFFFF, 1'(b == 0), 30);
        end
      end
    end
    idle();
    dst_mode = 1;
    @(posedge clk); #2;
    wait_drain();

    // non-contiguous KEEP on a LAST beat
`ifdef PTC_AXI2MFB_KEEP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    chk("keep_err_clean", DW'(KEEP_ERR), DW'(1'b0));
    send_beat(rnd_data(), rnd_meta(), 1'b1, 16'h00F5, 1'b1, 0);
    idle();
    chk("keep_err_set", DW'(KEEP_ERR), DW'(exp_err));
    repeat (3) @(posedge clk);
    #2;
    chk("keep_err_held", DW'(KEEP_ERR), DW'(exp_err));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
